// File: rtl/chan_acc_requant_if.sv
// Stream bundle for chan_acc_requant: group config, partial-sum input channel and
// int8 result output channel, each with a valid/ready pair.
interface chan_acc_requant_if #(
  parameter int SUM_WIDTH = 20,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 10
);
  logic        [CNT_WIDTH-1:0] cfg_ch_num;
  logic signed [ACC_WIDTH-1:0] cfg_bias;
  logic        [4:0]           cfg_shift;
  logic                        cfg_relu;
  logic                        acc_clr;

  logic                        psum_vld;
  logic                        psum_rdy;
  logic signed [SUM_WIDTH-1:0] psum;

  logic                        out_vld;
  logic                        out_rdy;
  logic signed [7:0]           out_data;

  // Producer/consumer side (drives psums and config, accepts results)
  modport master (
    output cfg_ch_num, cfg_bias, cfg_shift, cfg_relu, acc_clr,
    output psum_vld, psum, out_rdy,
    input  psum_rdy, out_vld, out_data
  );

  // Accumulator/requantiser side
  modport slave (
    input  cfg_ch_num, cfg_bias, cfg_shift, cfg_relu, acc_clr,
    input  psum_vld, psum, out_rdy,
    output psum_rdy, out_vld, out_data
  );
endinterface

// File: rtl/chan_acc_requant.sv
// Per-channel accumulation of signed 3x3 partial sums, bias add, rounding right shift,
// optional ReLU and int8 saturation. Two pipeline stages with valid/ready backpressure.
module chan_acc_requant #(
  parameter int SUM_WIDTH = 20,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 10
) (
  input logic               clk,
  input logic               rst,
  chan_acc_requant_if.slave bus
);

  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(127);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -(ACC_WIDTH+1)'(128);

  // Accumulate stage state
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CNT_WIDTH-1:0] r_cnt;
  logic        [CNT_WIDTH-1:0] r_ch_num;
  logic signed [ACC_WIDTH-1:0] r_bias;
  logic        [4:0]           r_shift;
  logic                        r_relu;

  // Finished-group register feeding the requant stage
  logic signed [ACC_WIDTH-1:0] r_fin;
  logic        [4:0]           r_fin_shift;
  logic                        r_fin_relu;
  logic                        r_fin_vld;

  // Output register
  logic                        r_out_vld;
  logic signed [7:0]           r_out_data;

  logic                        w_first;
  logic        [CNT_WIDTH-1:0] w_ch_cfg;
  logic        [CNT_WIDTH-1:0] w_ch_eff;
  logic signed [ACC_WIDTH-1:0] w_bias_eff;
  logic        [4:0]           w_shift_eff;
  logic                        w_relu_eff;
  logic        [CNT_WIDTH:0]   w_cnt_inc;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_psum_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_b_adv;
  logic                        w_psum_rdy;
  logic                        w_xfer;

  // The first psum of a group uses the live config; later psums use the latched copy.
  assign w_first     = (r_cnt == '0);
  assign w_ch_cfg    = (bus.cfg_ch_num == '0) ? CNT_WIDTH'(1) : bus.cfg_ch_num;
  assign w_ch_eff    = w_first ? w_ch_cfg      : r_ch_num;
  assign w_bias_eff  = w_first ? bus.cfg_bias  : r_bias;
  assign w_shift_eff = w_first ? bus.cfg_shift : r_shift;
  assign w_relu_eff  = w_first ? bus.cfg_relu  : r_relu;

  assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);
  assign w_last     = (w_cnt_inc == {1'b0, w_ch_eff});
  assign w_psum_ext = {{(ACC_WIDTH-SUM_WIDTH){bus.psum[SUM_WIDTH-1]}}, bus.psum};
  assign w_sum      = r_acc + w_psum_ext;

  // Every psum waits until the fin slot is free or draining, so a group end never blocks.
  assign w_b_adv    = ~r_out_vld | bus.out_rdy;
  assign w_psum_rdy = ~bus.acc_clr & (~r_fin_vld | w_b_adv);
  assign w_xfer     = bus.psum_vld & w_psum_rdy;

  assign bus.psum_rdy = w_psum_rdy;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ch_num <= CNT_WIDTH'(1);
      r_bias   <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      if (w_first) begin
        r_ch_num <= w_ch_cfg;
        r_bias   <= bus.cfg_bias;
        r_shift  <= bus.cfg_shift;
        r_relu   <= bus.cfg_relu;
      end
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
      end
    end
  end

  logic w_load_fin;
  assign w_load_fin = w_xfer & w_last & ~bus.acc_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin       <= '0;
      r_fin_shift <= '0;
      r_fin_relu  <= 1'b0;
      r_fin_vld   <= 1'b0;
    end else begin
      if (w_load_fin) begin
        r_fin       <= w_sum + w_bias_eff;
        r_fin_shift <= w_shift_eff;
        r_fin_relu  <= w_relu_eff;
        r_fin_vld   <= 1'b1;
      end else if (w_b_adv) begin
        r_fin_vld   <= 1'b0;
      end
    end
  end

  // Requantisation of the finished sum: round half up, arithmetic shift, ReLU, saturate.
  logic        [ACC_WIDTH:0]   w_half;
  logic signed [ACC_WIDTH:0]   w_round;
  logic signed [ACC_WIDTH:0]   w_shifted;
  logic signed [7:0]           w_q;

  always_comb begin
    w_half    = '0;
    w_round   = {r_fin[ACC_WIDTH-1], r_fin};
    w_shifted = '0;
    w_q       = '0;
    if (r_fin_shift != 5'd0) begin
      w_half  = {{ACC_WIDTH{1'b0}}, 1'b1} << (r_fin_shift - 5'd1);
      w_round = w_round + $signed(w_half);
    end
    w_shifted = w_round >>> r_fin_shift;
    if (r_fin_relu && (w_shifted < 0)) begin
      w_shifted = '0;
    end
    if (w_shifted > SAT_MAX) begin
      w_q = 8'sd127;
    end else if (w_shifted < SAT_MIN) begin
      w_q = -8'sd128;
    end else begin
      w_q = w_shifted[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else if (w_b_adv) begin
      r_out_vld <= r_fin_vld;
      if (r_fin_vld) begin
        r_out_data <= w_q;
      end
    end
  end

endmodule

// File: tb/tb_chan_acc_requant.sv
// Directed bench for chan_acc_requant: expected results queued at issue time,
// a negedge monitor pops and compares on every output transfer.
module tb_chan_acc_requant;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_q[$];

  chan_acc_requant_if #(.SUM_WIDTH(20), .ACC_WIDTH(32), .CNT_WIDTH(10)) bus ();

  chan_acc_requant #(.SUM_WIDTH(20), .ACC_WIDTH(32), .CNT_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s = %0d at %0t", name, act, $time);
    end
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%0d required=none at %0t",
                 int'($signed(bus.out_data)), $time);
      end else begin
        chk("out_data", int'($signed(bus.out_data)), exp_q.pop_front());
      end
    end
  end

  // Present one psum and return just after the edge that accepts it.
  task automatic send(input int v, input bit push, input int req);
    int n;
    bus.psum_vld = 1'b1;
    bus.psum     = 20'(v);
    if (push) exp_q.push_back(req);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.psum_rdy === 1'b1) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL psum_accept_timeout actual=0 required=1 at %0t", $time);
        break;
      end
    end
    bus.psum_vld = 1'b0;
  endtask

  task automatic set_cfg(input int ch, input int bias, input int sh, input bit relu);
    bus.cfg_ch_num = 10'(ch);
    bus.cfg_bias   = 32'(bias);
    bus.cfg_shift  = 5'(sh);
    bus.cfg_relu   = relu;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.acc_clr = 1'b0;
    bus.psum_vld = 1'b0;
    bus.psum = '0;
    bus.out_rdy = 1'b1;
    set_cfg(1, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", int'(bus.out_vld), 0);
    chk("rst_out_data", int'($signed(bus.out_data)), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_psum_rdy", int'(bus.psum_rdy), 1);
    @(posedge clk);
    #1;

    // 1) three-channel sum, latency, mid-group config change ignored
    set_cfg(3, 0, 0, 1'b0);
    send(10, 1'b0, 0);
    set_cfg(5, 1000, 3, 1'b1);
    send(20, 1'b0, 0);
    send(30, 1'b1, 60);
    @(negedge clk);
    chk("lat_T1_out_vld", int'(bus.out_vld), 0);
    @(negedge clk);
    chk("lat_T2_out_vld", int'(bus.out_vld), 1);
    @(negedge clk);
    chk("lat_T3_out_vld", int'(bus.out_vld), 0);
    @(posedge clk);
    #1;

    // 2) bias and rounding shift, positive and negative
    set_cfg(2, -5, 2, 1'b0);
    send(7, 1'b0, 0);
    send(6, 1'b1, 2);
    set_cfg(2, 0, 2, 1'b0);
    send(-7, 1'b0, 0);
    send(-6, 1'b1, -3);

    // 3) saturation and ReLU
    set_cfg(1, 0, 0, 1'b0);
    send(500, 1'b1, 127);
    send(-500, 1'b1, -128);
    set_cfg(1, 0, 0, 1'b1);
    send(-500, 1'b1, 0);
    send(500, 1'b1, 127);
    repeat (4) @(posedge clk);
    #1;

    // 4) backpressure
    set_cfg(1, 0, 0, 1'b0);
    bus.out_rdy = 1'b0;
    send(1, 1'b1, 1);
    send(2, 1'b1, 2);
    bus.psum_vld = 1'b1;
    bus.psum = 20'(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_psum_rdy", int'(bus.psum_rdy), 0);
      chk("stall_out_vld", int'(bus.out_vld), 1);
      chk("stall_out_data", int'($signed(bus.out_data)), 1);
      @(posedge clk);
      #1;
    end
    bus.out_rdy = 1'b1;
    send(3, 1'b1, 3);
    send(4, 1'b1, 4);
    repeat (4) @(posedge clk);
    #1;

    // 5) acc_clr mid-group; psum offered during clr must not be consumed
    set_cfg(4, 0, 0, 1'b0);
    send(100, 1'b0, 0);
    send(100, 1'b0, 0);
    bus.acc_clr = 1'b1;
    bus.psum_vld = 1'b1;
    bus.psum = 20'(77);
    @(negedge clk);
    chk("clr_psum_rdy", int'(bus.psum_rdy), 0);
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    bus.psum_vld = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 1'b0, 0);
    send(1, 1'b1, 4);
    repeat (4) @(posedge clk);
    #1;

    // 6) reset while output stalled and a group is half accumulated
    bus.out_rdy = 1'b0;
    set_cfg(1, 0, 0, 1'b0);
    send(9, 1'b1, 9);
    set_cfg(3, 0, 0, 1'b0);
    send(50, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_out_vld", int'(bus.out_vld), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_vld", int'(bus.out_vld), 0);
    chk("mid_rst_out_data", int'($signed(bus.out_data)), 0);
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    send(3, 1'b1, 6);

    // drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
